vending_machine_ctrl: RTL and testbench

Parametrised vending-machine controller: accumulates coin credit, applies a per-item discount to a per-item price, and dispenses the selected item over a valid/ready handshake. It then returns remaining change over a second handshake. It is the multi-item, multi-discount successor to the single-selection vending FSM and sits between the coin acceptor, keypad decoder and dispenser/change units.

---
 rtl/vending_machine_ctrl.sv | 145 ++++++++++++++
 tb/tb_vending_machine_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_ctrl.sv
// Vending-machine controller: coin credit accumulation, per-item discounted pricing,
// dispense over a valid/ready handshake, then change return over a second handshake.
module vending_machine_ctrl #(
   parameter  int DW      = 64,
   parameter  int N_ITEMS = 4,
   localparam int SEL_W   = $clog2(N_ITEMS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  coin_valid,
   input  logic [DW-1:0]         coin_value,
   output logic                  coin_ready,
   input  logic                  sel_valid,
   input  logic [SEL_W-1:0]      sel_item,
   input  logic                  cancel,
   input  logic [N_ITEMS*DW-1:0] price,
   input  logic [N_ITEMS*DW-1:0] discount,
   output logic                  vend_valid,
   output logic [SEL_W-1:0]      vend_item,
   input  logic                  vend_ready,
   output logic                  change_valid,
   output logic [DW-1:0]         change_value,
   input  logic                  change_ready,
   output logic                  deny,
   output logic [DW-1:0]         credit,
   output logic [31:0]           sales_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CREDIT = 2'd1,
      S_VEND   = 2'd2,
      S_CHANGE = 2'd3
   } state_t;

   state_t            r_state;
   logic [DW-1:0]     r_credit;
   logic              r_vend_valid;
   logic              r_change_valid;
   logic              r_deny;
   logic [SEL_W-1:0]  r_vend_item;
   logic [31:0]       r_sales;

   logic [DW-1:0]     w_eff;
   logic              w_sel_ok;
   logic              w_vend_ok;
   logic [DW-1:0]     w_coin;
   logic [DW-1:0]     w_base;
   logic [DW:0]       w_sum;
   logic [DW-1:0]     w_next_credit;

   // Effective price of the selected item, read live from the buses; an index with
   // no matching item leaves w_sel_ok low so the selection is denied.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_eff    = '0;
      w_sel_ok = 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (sel_item == SEL_W'(i)) begin
            w_sel_ok = 1'b1;
            w_eff    = (discount[i*DW +: DW] > price[i*DW +: DW]) ? '0
                       : price[i*DW +: DW] - discount[i*DW +: DW];
         end
      end
   end

   assign w_vend_ok = w_sel_ok && (r_credit >= w_eff);
   assign w_coin    = coin_valid ? coin_value : '0;

   // One saturating adder serves every CREDIT outcome; a vend subtracts first.
   assign w_base        = (sel_valid && !cancel && w_vend_ok) ? r_credit - w_eff : r_credit;
   assign w_sum         = {1'b0, w_base} + {1'b0, w_coin};
   assign w_next_credit = w_sum[DW] ? '1 : w_sum[DW-1:0];

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_credit       <= '0;
         r_vend_valid   <= 1'b0;
         r_change_valid <= 1'b0;
         r_deny         <= 1'b0;
         r_vend_item    <= '0;
         r_sales        <= '0;
      end else begin
         r_deny <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (coin_valid) begin
                  r_credit <= coin_value;
                  r_state  <= S_CREDIT;
               end
            end
            S_CREDIT: begin
               r_credit <= w_next_credit;
               if (cancel) begin
                  r_change_valid <= 1'b1;
                  r_state        <= S_CHANGE;
               end else if (sel_valid && w_vend_ok) begin
                  r_vend_item  <= sel_item;
                  r_vend_valid <= 1'b1;
                  r_state      <= S_VEND;
               end else if (sel_valid) begin
                  r_deny <= 1'b1;
               end
            end
            S_VEND: begin
               if (r_vend_valid && vend_ready) begin
                  r_sales      <= r_sales + 32'd1;
                  r_vend_valid <= 1'b0;
                  if (r_credit == '0) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_change_valid <= 1'b1;
                     r_state        <= S_CHANGE;
                  end
               end
            end
            S_CHANGE: begin
               if (r_change_valid && change_ready) begin
                  r_credit       <= '0;
                  r_change_valid <= 1'b0;
                  r_state        <= S_IDLE;
               end
            end
            default: begin
               r_state        <= S_IDLE;
               r_credit       <= '0;
               r_vend_valid   <= 1'b0;
               r_change_valid <= 1'b0;
            end
         endcase
      end
   end

   assign coin_ready   = (r_state == S_IDLE) || (r_state == S_CREDIT);
   assign vend_valid   = r_vend_valid;
   assign vend_item    = r_vend_item;
   assign change_valid = r_change_valid;
   assign change_value = r_credit;
   assign deny         = r_deny;
   assign credit       = r_credit;
   assign sales_count  = r_sales;

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Self-checking bench for vending_machine_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a flag-based transaction model.
module tb_vending_machine_ctrl;

   localparam int DW = 64;
   localparam int N  = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            coin_valid;
   logic [DW-1:0]   coin_value;
   logic            coin_ready;
   logic            sel_valid;
   logic [1:0]      sel_item;
   logic            cancel;
   logic [N*DW-1:0] price;
   logic [N*DW-1:0] discount;
   logic            vend_valid;
   logic [1:0]      vend_item;
   logic            vend_ready;
   logic            change_valid;
   logic [DW-1:0]   change_value;
   logic            change_ready;
   logic            deny;
   logic [DW-1:0]   credit;
   logic [31:0]     sales_count;

   vending_machine_ctrl #(.DW(DW), .N_ITEMS(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_value   (coin_value),
      .coin_ready   (coin_ready),
      .sel_valid    (sel_valid),
      .sel_item     (sel_item),
      .cancel       (cancel),
      .price        (price),
      .discount     (discount),
      .vend_valid   (vend_valid),
      .vend_item    (vend_item),
      .vend_ready   (vend_ready),
      .change_valid (change_valid),
      .change_value (change_value),
      .change_ready (change_ready),
      .deny         (deny),
      .credit       (credit),
      .sales_count  (sales_count)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] p_arr [N];
   logic [DW-1:0] d_arr [N];

   always_comb begin
      price    = '0;
      discount = '0;
      for (int i = 0; i < N; i++) begin
         price[i*DW +: DW]    = p_arr[i];
         discount[i*DW +: DW] = d_arr[i];
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Model: a session is open once a coin lands in idle; a pending vend or refund
   // blocks coins until its handshake completes.
   logic [DW-1:0] m_credit;
   bit            m_sess, m_vend, m_change, m_deny;
   logic [1:0]    m_item;
   logic [31:0]   m_sales;

   function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [DW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[DW] ? {DW{1'b1}} : s[DW-1:0];
   endfunction

   function automatic logic [DW-1:0] eff_of(input int i);
      return (p_arr[i] > d_arr[i]) ? p_arr[i] - d_arr[i] : '0;
   endfunction

   task automatic model_reset();
      m_credit = '0; m_sess = 0; m_vend = 0; m_change = 0; m_deny = 0;
      m_item = '0; m_sales = '0;
   endtask

   task automatic model_step(input bit cv, input logic [DW-1:0] cval, input bit sv,
                             input logic [1:0] si, input bit cn, input bit vr, input bit cr);
      logic [DW-1:0] coin;
      m_deny = 0;
      coin   = cv ? cval : '0;
      if (m_vend) begin
         if (vr) begin
            m_sales = m_sales + 1;
            m_vend  = 0;
            if (m_credit != 0) m_change = 1;
            else m_sess = 0;
         end
      end else if (m_change) begin
         if (cr) begin
            m_change = 0; m_credit = '0; m_sess = 0;
         end
      end else if (!m_sess) begin
         if (cv) begin
            m_sess = 1; m_credit = cval;
         end
      end else if (cn) begin
         m_credit = sat_add(m_credit, coin);
         m_change = 1;
      end else if (sv && int'(si) < N && m_credit >= eff_of(int'(si))) begin
         m_credit = sat_add(m_credit - eff_of(int'(si)), coin);
         m_vend   = 1;
         m_item   = si;
      end else begin
         if (sv) m_deny = 1;
         m_credit = sat_add(m_credit, coin);
      end
   endtask

   task automatic compare_all();
      check($sformatf("c%0d coin_ready", cyc), DW'(coin_ready), DW'(!(m_vend || m_change)));
      check($sformatf("c%0d vend_valid", cyc), DW'(vend_valid), DW'(m_vend));
      if (m_vend) check($sformatf("c%0d vend_item", cyc), DW'(vend_item), DW'(m_item));
      check($sformatf("c%0d change_valid", cyc), DW'(change_valid), DW'(m_change));
      check($sformatf("c%0d change_value", cyc), change_value, m_credit);
      check($sformatf("c%0d credit", cyc), credit, m_credit);
      check($sformatf("c%0d deny", cyc), DW'(deny), DW'(m_deny));
      check($sformatf("c%0d sales_count", cyc), DW'(sales_count), DW'(m_sales));
   endtask

   task automatic cycle(input bit cv, input logic [DW-1:0] cval, input bit sv,
                        input logic [1:0] si, input bit cn, input bit vr, input bit cr);
      coin_valid = cv; coin_value = cval; sel_valid = sv; sel_item = si;
      cancel = cn; vend_ready = vr; change_ready = cr;
      model_step(cv, cval, sv, si, cn, vr, cr);
      @(posedge clk);
      #1;
      cyc++;
      compare_all();
   endtask

   task automatic idle_inputs();
      coin_valid = 0; coin_value = '0; sel_valid = 0; sel_item = '0;
      cancel = 0; vend_ready = 0; change_ready = 0;
   endtask

   task automatic check_reset_values(input string tag);
      model_reset();
      compare_all();
      check({tag, " vend_item"}, DW'(vend_item), '0);
   endtask

   initial begin
      idle_inputs();
      p_arr[0] = 100; d_arr[0] = 0;
      p_arr[1] = 80;  d_arr[1] = 30;
      p_arr[2] = 90;  d_arr[2] = 20;
      p_arr[3] = 50;  d_arr[3] = 200;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;

      // Discounted exact-credit vend with ready tied high
      cycle(1, 50, 0, 0, 0, 1, 0);
      cycle(0, 0,  1, 1, 0, 1, 0);
      cycle(0, 0,  0, 0, 0, 1, 0);

      // Vend with remainder, then stalled change return
      cycle(1, 100, 0, 0, 0, 0, 0);
      cycle(1, 25,  0, 0, 0, 0, 0);
      cycle(0, 0,   1, 0, 0, 0, 0);
      cycle(0, 0,   0, 0, 0, 1, 0);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0,   0, 0, 0, 0, 1);

      // Deny on insufficient credit, then refund
      cycle(1, 40, 0, 0, 0, 0, 0);
      cycle(0, 0,  1, 2, 0, 0, 0);
      cycle(0, 0,  0, 0, 0, 0, 0);
      cycle(0, 0,  0, 0, 1, 0, 0);
      cycle(0, 0,  0, 0, 0, 0, 1);

      // Discount above price clamps to free; credit saturation
      cycle(1, 10, 0, 0, 0, 0, 0);
      cycle(0, 0,  1, 3, 0, 1, 0);
      cycle(0, 0,  0, 0, 0, 1, 0);
      cycle(0, 0,  0, 0, 0, 0, 1);
      cycle(1, {DW{1'b1}} - 4, 0, 0, 0, 0, 0);
      cycle(1, 10, 0, 0, 0, 0, 0);
      check("saturated credit", credit, {DW{1'b1}});
      cycle(0, 0,  0, 0, 1, 0, 0);
      cycle(0, 0,  0, 0, 0, 0, 1);

      // Coin folded into a vend; cancel wins over select
      p_arr[0] = 60; d_arr[0] = 0;
      cycle(1, 60, 0, 0, 0, 0, 0);
      cycle(1, 5,  1, 0, 0, 1, 0);
      cycle(0, 0,  0, 0, 0, 1, 0);
      check("folded coin change", change_value, 64'd5);
      cycle(0, 0,  0, 0, 0, 0, 1);
      cycle(1, 60, 0, 0, 0, 0, 0);
      cycle(0, 0,  1, 0, 1, 1, 0);
      cycle(0, 0,  0, 0, 0, 0, 1);

      // Reset in the middle of a stalled vend handshake
      cycle(1, 50, 0, 0, 0, 0, 0);
      cycle(0, 0,  1, 1, 0, 0, 0);
      reset = 1'b1;
      #1;
      check_reset_values("mid-vend reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_inputs();
      cycle(1, 30, 0, 0, 0, 0, 0);
      cycle(0, 0,  0, 0, 1, 0, 0);
      cycle(0, 0,  0, 0, 0, 0, 1);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         bit            cv, sv, cn, vr, cr;
         logic [DW-1:0] cval;
         logic [1:0]    si;
         if ($urandom_range(0, 15) == 0) begin
            int j;
            j = $urandom_range(0, N-1);
            p_arr[j] = DW'($urandom_range(0, 200));
            d_arr[j] = DW'($urandom_range(0, 250));
         end
         cv   = ($urandom_range(0, 2) == 0);
         cval = ($urandom_range(0, 31) == 0) ? {DW{1'b1}} - DW'($urandom_range(0, 255))
                                              : DW'($urandom_range(0, 100));
         sv   = ($urandom_range(0, 3) == 0);
         si   = 2'($urandom_range(0, N-1));
         cn   = ($urandom_range(0, 15) == 0);
         vr   = ($urandom_range(0, 1) == 1);
         cr   = ($urandom_range(0, 1) == 1);
         cycle(cv, cval, sv, si, cn, vr, cr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
